spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 64, WAIT-state cycle limit before aborting a transfer (legal range 4..255).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  3  per-requester transfer request, level, bit i = requester i.
REQ-005 req_data  input  24  requester payloads; requester i uses req_data[8i+7:8i].
REQ-006 ack  output  3  one-cycle completion pulse to the granted requester.
REQ-007 err  output  1  one-cycle timeout pulse; grant_id identifies the aborted requester.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 grant_id  output  2  index of the current or last granted requester (0..2).
REQ-010 m_start  output  1  start strobe to the SPI master.
REQ-011 m_data  output  8  byte to the SPI master's data input.
REQ-012 m_done  input  1  completion strobe from the SPI master.

Function
REQ-013 The block SHALL share one SPI master among three requesters, one byte transfer at a time.
REQ-014 FSM states SHALL be IDLE, LAUNCH, WAIT, COMPLETE, ABORT; all outputs registered.
REQ-015 IDLE: if any req bit is high, select the winner round-robin, starting from (last_grant+1) mod 3 and searching upward with wrap; latch its payload into m_data and its index into grant_id; go to LAUNCH. Otherwise stay in IDLE.
REQ-016 LAUNCH: m_start=1 for exactly this one cycle; clear the timeout counter; go to WAIT.
REQ-017 WAIT: m_start=0; the counter increments every cycle; m_done=1 -> COMPLETE; otherwise, when the counter reaches TIMEOUT-1 -> ABORT.
REQ-018 If m_done=1 in the same cycle the counter reaches TIMEOUT-1, m_done SHALL win (COMPLETE).
REQ-019 COMPLETE: ack[grant_id]=1 for one cycle; set last_grant to grant_id; go to IDLE.
REQ-020 ABORT: err=1 for one cycle; no ack; set last_grant to grant_id; go to IDLE.
REQ-021 m_data SHALL be held constant from LAUNCH until the state returns to IDLE.
REQ-022 m_done SHALL be ignored in IDLE, LAUNCH, COMPLETE and ABORT.
REQ-023 Latency: a req first sampled high in IDLE gives m_start high on the next cycle; ack appears one cycle after m_done is sampled.
REQ-024 Requester contract: a requester holds req and req_data stable until its ack or err, then drops req in the following cycle. Changes to req_data after the grant SHALL NOT affect m_data.
REQ-025 A req withdrawn before being granted SHALL be ignored with no side effects.
REQ-026 At least one IDLE cycle SHALL separate consecutive transfers. Maximum m_start rate is one per 4 cycles plus the master's transfer time.
REQ-027 Fairness: with all three requesters continuously requesting, grants SHALL cycle 0,1,2,0,...

Reset
REQ-028 While rst_n=0: state=IDLE, last_grant=2 (requester 0 has first priority), counter=0, ack=0, err=0, busy=0, grant_id=0, m_start=0, m_data=8'h00.
REQ-029 Reset asserted mid-transfer SHALL abort immediately with no ack or err pulse. After release, the arbiter restarts in IDLE.

Verification
REQ-030 Single request: req=3'b010, req_data[15:8]=8'hA5; master returns m_done 20 cycles after m_start -> m_start pulse of 1 cycle, m_data=8'hA5 held, grant_id=1, ack=3'b010 one cycle after m_done, busy drops the cycle after that.
REQ-031 Round-robin: req=3'b111 held, each requester re-raising req after its ack -> grant order 0,1,2,0 with payloads 8'h11, 8'h22, 8'h33, 8'h11 on m_data.
REQ-032 Timeout: req=3'b001, m_done never asserted -> err pulse exactly TIMEOUT+1 cycles after m_start, ack stays 0, next grant begins from requester 1.
REQ-033 Boundary: m_done asserted on the cycle the counter equals TIMEOUT-1 -> ack pulse, no err.
REQ-034 Reset mid-WAIT: rst_n=0 for 2 cycles during WAIT -> all outputs at reset values, no ack or err. A subsequent req=3'b100 is granted with grant_id=2.
REQ-035 Stray/withdrawn: m_done pulsed while in IDLE -> no ack. req=3'b010 raised while requester 0 is in WAIT and dropped before COMPLETE -> never granted.

Source files
------------

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among three requesters, one byte per grant.
// req->m_start 1 cycle, m_done->ack 1 cycle; requesters wait on req until ack/err, stalled master aborts after TIMEOUT.
module spi_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [23:0] req_data,
  output logic [2:0]  ack,
  output logic        err,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        m_start,
  output logic [7:0]  m_data,
  input  logic        m_done
);

  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    COMPLETE,
    ABORT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic [1:0]  last_grant;
  logic        win_vld;
  logic [1:0]  win_id;

  // Index of the requester 'ofs' places after 'base', wrapping modulo 3.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] ofs);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, ofs} + 3'd1;
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Walk candidates from farthest to nearest so the nearest active requester wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (req[rr_idx(last_grant, 2'(k))]) begin
        win_vld = 1'b1;
        win_id  = rr_idx(last_grant, 2'(k));
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (win_vld) state_nxt = LAUNCH;
      LAUNCH:   state_nxt = WAIT;
      WAIT: begin
        if (m_done)              state_nxt = COMPLETE;
        else if (cnt == CNT_MAX) state_nxt = ABORT;
      end
      COMPLETE: state_nxt = IDLE;
      ABORT:    state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outputs are decoded from the next state so each one is a clean register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 8'd0;
      last_grant <= 2'd2;
      ack        <= 3'b000;
      err        <= 1'b0;
      busy       <= 1'b0;
      grant_id   <= 2'd0;
      m_start    <= 1'b0;
      m_data     <= 8'h00;
    end else begin
      if (state == LAUNCH)    cnt <= 8'd0;
      else if (state == WAIT) cnt <= cnt + 8'd1;

      if (state == IDLE && win_vld) begin
        grant_id <= win_id;
        m_data   <= req_data[{win_id, 3'b000} +: 8];
      end

      if (state == COMPLETE || state == ABORT) last_grant <= grant_id;

      m_start <= (state_nxt == LAUNCH);
      busy    <= (state_nxt != IDLE);
      err     <= (state_nxt == ABORT);
      ack     <= (state_nxt == COMPLETE) ? (3'b001 << grant_id) : 3'b000;
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: expected grants queued at stimulus time, checked on m_start/ack/err.
module tb_spi_arbiter;

  localparam int TO = 64;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [23:0] req_data;
  logic [2:0]  ack;
  logic        err;
  logic        busy;
  logic [1:0]  grant_id;
  logic        m_start;
  logic [7:0]  m_data;
  logic        m_done;

  spi_arbiter #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .err      (err),
    .busy     (busy),
    .grant_id (grant_id),
    .m_start  (m_start),
    .m_data   (m_data),
    .m_done   (m_done)
  );

  typedef struct {
    logic [1:0] grant;
    logic [7:0] data;
    bit         is_to;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t cur;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_start = 0;
  int n_ack   = 0;
  int n_err   = 0;
  bit active  = 0;
  int start_cyc = -1;
  int done_cyc  = -1;
  int busy_chk  = -1;
  int snap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [1:0] g, input logic [7:0] d, input bit to);
    xfer_t x;
    x.grant = g;
    x.data  = d;
    x.is_to = to;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_start) return;
    end
    chk("start_seen", int'(m_start), 1);
  endtask

  // Call at the negedge of the m_start cycle; m_done is high during the d-th cycle after it.
  task automatic pulse_done(input int d);
    repeat (d) @(posedge clk);
    #1 m_done = 1'b1;
    @(posedge clk);
    #1 m_done = 1'b0;
  endtask

  task automatic wait_end();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ack != 3'b000 || err) return;
    end
    chk("end_seen", int'(ack != 3'b000 || err), 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ack",      int'(ack),      0);
    chk("rst_err",      int'(err),      0);
    chk("rst_busy",     int'(busy),     0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_m_start",  int'(m_start),  0);
    chk("rst_m_data",   int'(m_data),   0);
  endtask

  // Monitor: pops the scoreboard on each launch and checks completion/abort timing.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        active   = 0;
        busy_chk = -1;
        done_cyc = -1;
      end else begin
        if (active && cyc == start_cyc + 1) chk("start_width", int'(m_start), 0);
        if (m_start && !(active && cyc == start_cyc + 1)) begin
          n_start++;
          chk("sb_nonempty", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("grant_id", int'(grant_id), int'(cur.grant));
            chk("m_data",   int'(m_data),   int'(cur.data));
            active    = 1;
            start_cyc = cyc;
            done_cyc  = -1;
          end
        end
        if (active && m_done && cyc != start_cyc && done_cyc < 0) done_cyc = cyc;
        if (ack != 3'b000) begin
          n_ack++;
          chk("ack_when_active", int'(active), 1);
          if (active) begin
            chk("ack_onehot",  int'(ack), int'(3'b001 << cur.grant));
            chk("ack_not_to",  int'(cur.is_to), 0);
            chk("ack_latency", cyc - done_cyc, 1);
            chk("ack_no_err",  int'(err), 0);
            chk("m_data_held", int'(m_data), int'(cur.data));
            active   = 0;
            busy_chk = cyc + 1;
          end
        end
        if (err) begin
          n_err++;
          chk("err_when_active", int'(active), 1);
          if (active) begin
            chk("err_is_to",   int'(cur.is_to), 1);
            chk("err_latency", cyc - start_cyc, TO + 1);
            chk("err_grant",   int'(grant_id), int'(cur.grant));
            active   = 0;
            busy_chk = cyc + 1;
          end
        end
        if (cyc == busy_chk) chk("busy_drop", int'(busy), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    req      = 3'b000;
    req_data = 24'h000000;
    m_done   = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    tick();
    rst_n = 1'b1;
    tick();

    // Fairness from reset: all three requesting continuously.
    req_data = 24'h332211;
    push_exp(2'd0, 8'h11, 0);
    push_exp(2'd1, 8'h22, 0);
    push_exp(2'd2, 8'h33, 0);
    push_exp(2'd0, 8'h11, 0);
    req = 3'b111;
    for (int n = 0; n < 4; n++) begin
      wait_start();
      pulse_done(5);
      wait_end();
    end
    tick();
    req = 3'b000;
    repeat (2) tick();

    // Single request, grant latency, payload change after grant must not leak.
    req_data = 24'h77A566;
    push_exp(2'd1, 8'hA5, 0);
    req = 3'b010;
    @(negedge clk);
    chk("start_early", int'(m_start), 0);
    @(negedge clk);
    chk("start_lat", int'(m_start), 1);
    chk("busy_in_launch", int'(busy), 1);
    req_data[15:8] = 8'h5A;
    pulse_done(20);
    wait_end();
    tick();
    req = 3'b000;
    tick();

    // Timeout, then rotation continues from requester 1.
    req_data = 24'h3322C1;
    push_exp(2'd0, 8'hC1, 1);
    req = 3'b001;
    wait_start();
    wait_end();
    chk("to_no_ack", int'(ack), 0);
    tick();
    req = 3'b111;
    push_exp(2'd1, 8'h22, 0);
    wait_start();
    pulse_done(4);
    wait_end();
    tick();
    req = 3'b000;
    tick();

    // m_done exactly at the last counter value, and one cycle earlier.
    req_data = 24'h000011;
    req = 3'b001;
    push_exp(2'd0, 8'h11, 0);
    wait_start();
    pulse_done(TO);
    wait_end();
    tick();
    req = 3'b000;
    tick();
    req = 3'b001;
    push_exp(2'd0, 8'h11, 0);
    wait_start();
    pulse_done(TO - 1);
    wait_end();
    tick();
    req = 3'b000;
    tick();

    // Reset in the middle of WAIT.
    req = 3'b001;
    push_exp(2'd0, 8'h11, 0);
    wait_start();
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    req = 3'b000;
    @(negedge clk);
    chk_reset_vals();
    @(negedge clk);
    chk("rst2_ack",  int'(ack),  0);
    chk("rst2_err",  int'(err),  0);
    chk("rst2_busy", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();
    req_data = 24'hC30011;
    req = 3'b100;
    push_exp(2'd2, 8'hC3, 0);
    wait_start();
    pulse_done(3);
    wait_end();
    tick();
    req = 3'b000;
    tick();

    // Requester 1 raises and withdraws while requester 0 is in WAIT.
    req_data = 24'h00BB11;
    req = 3'b001;
    push_exp(2'd0, 8'h11, 0);
    wait_start();
    tick();
    req = 3'b011;
    repeat (3) @(posedge clk);
    #1 req = 3'b001;
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    wait_end();
    tick();
    req = 3'b000;
    snap = n_start;
    repeat (10) tick();
    chk("withdrawn_no_start", n_start, snap);

    // Stray m_done while idle.
    snap = n_ack;
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("stray_no_ack", n_ack, snap);
    chk("stray_idle",   int'(busy), 0);

    chk("sb_drained", exp_q.size(), 0);
    chk("ack_count",  n_ack, 10);
    chk("err_count",  n_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
